// File: rtl/cavlc_pkg.sv
// Shared types and widths for the CAVLC bitstream fetch path.
// Holds the fetch FSM state type and buffer geometry.
package cavlc_pkg;

  localparam int WORD_W = 32;
  localparam int BUF_W  = 64;
  localparam int CNT_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_ERR
  } fetch_state_t;

endpackage

// File: rtl/bit_buffer.sv
// 64-bit MSB-aligned bit buffer with shift-out and word merge.
// Valid bits sit at buf_q[63:64-count]; everything below is kept 0.
module bit_buffer
  import cavlc_pkg::*;
(
  input  logic              Clk,
  input  logic              nReset,
  input  logic              clear,
  input  logic              accept,
  input  logic [4:0]        shift_amt,
  input  logic [WORD_W-1:0] word_data,
  output logic [WORD_W-1:0] bits_out,
  output logic [CNT_W-1:0]  count_q,
  output logic [CNT_W-1:0]  count_d
);

  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] buf_d;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] merged;
  logic [CNT_W-1:0] base;

  // Drop consumed bits, then append the new word right after the survivors.
  always_comb begin
    shifted = buf_q << shift_amt;
    base    = count_q - {2'b00, shift_amt};
    merged  = {word_data, {WORD_W{1'b0}}} >> base;
    buf_d   = shifted;
    count_d = base;
    if (accept) begin
      buf_d   = shifted | merged;
      count_d = base + 7'd32;
    end
    if (clear) begin
      buf_d   = '0;
      count_d = '0;
    end
  end

  // Buffer and fill-level registers.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  assign bits_out = buf_q[BUF_W-1:WORD_W];

endmodule

// File: rtl/bitstream_fetch_ctrl.sv
// Bitstream fetch controller: word intake, bit shifting, underflow trap.
// Define CAVLC_BITCNT_EN to add the BitsConsumed running bit counter.
module bitstream_fetch_ctrl
  import cavlc_pkg::*;
#(
  parameter int READY_BITS = 32
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              WordValid,
  input  logic [WORD_W-1:0] WordData,
  output logic              WordReady,
  input  logic              ShiftEn,
  input  logic [4:0]        NumShift,
  output logic [WORD_W-1:0] BitsOut,
  output logic              BarrelShifterReady,
`ifdef CAVLC_BITCNT_EN
  output logic [31:0]       BitsConsumed,
`endif
  output logic              Underflow
);

  localparam logic [CNT_W-1:0] READY_CNT = CNT_W'(READY_BITS);

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic             underflow_q;
  logic             underflow_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             in_run;
  logic             bad_shift;
  logic             hold;
  logic             accept;
  logic [4:0]       shift_amt;

  // Handshake and shift qualification from registered state only.
  always_comb begin
    in_run    = (state_q == ST_RUN);
    WordReady = ((state_q == ST_FILL) || in_run) && (count_q <= 7'd32);
    bad_shift = in_run && ShiftEn && ({2'b00, NumShift} > count_q);
    hold      = Start || Stop || bad_shift;
    accept    = WordValid && WordReady && !hold;
    shift_amt = (in_run && ShiftEn && !hold) ? NumShift : 5'd0;
  end

  bit_buffer u_buf (
    .Clk       (Clk),
    .nReset    (nReset),
    .clear     (Start),
    .accept    (accept),
    .shift_amt (shift_amt),
    .word_data (WordData),
    .bits_out  (BitsOut),
    .count_q   (count_q),
    .count_d   (count_d)
  );

  // Next-state logic; Start wins over Stop, both over normal flow.
  always_comb begin
    state_d     = state_q;
    underflow_d = underflow_q;
    if (Start) begin
      state_d     = ST_FILL;
      underflow_d = 1'b0;
    end else if (Stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_FILL: begin
          if (count_d >= READY_CNT) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (bad_shift) begin
            state_d     = ST_ERR;
            underflow_d = 1'b1;
          end
        end
        ST_ERR: state_d = ST_ERR;
      endcase
    end
  end

  // FSM state and sticky underflow flag.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= ST_IDLE;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      underflow_q <= underflow_d;
    end
  end

  assign Underflow          = underflow_q;
  assign BarrelShifterReady = in_run && (count_q >= READY_CNT);

`ifdef CAVLC_BITCNT_EN
  logic [31:0] bitcnt_q;
  logic [31:0] bitcnt_d;

  // Running total of shifted bits, cleared by Start.
  always_comb begin
    bitcnt_d = bitcnt_q + {27'd0, shift_amt};
    if (Start) bitcnt_d = '0;
  end

  // Bit counter register.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) bitcnt_q <= '0;
    else         bitcnt_q <= bitcnt_d;
  end

  assign BitsConsumed = bitcnt_q;
`endif

endmodule

// File: tb/tb_bitstream_fetch_ctrl.sv
// Self-checking bench for bitstream_fetch_ctrl (READY_BITS = 32).
// Queue-of-bits model checked every cycle plus literal anchors.
module tb_bitstream_fetch_ctrl;

  localparam int RB = 32;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        Start = 1'b0;
  logic        Stop = 1'b0;
  logic        WordValid = 1'b0;
  logic [31:0] WordData = '0;
  logic        WordReady;
  logic        ShiftEn = 1'b0;
  logic [4:0]  NumShift = '0;
  logic [31:0] BitsOut;
  logic        BarrelShifterReady;
  logic        Underflow;
`ifdef CAVLC_BITCNT_EN
  logic [31:0] BitsConsumed;
`endif

  int checks = 0;
  int failures = 0;

  bitstream_fetch_ctrl #(.READY_BITS(RB)) dut (
    .Clk                (Clk),
    .nReset             (nReset),
    .Start              (Start),
    .Stop               (Stop),
    .WordValid          (WordValid),
    .WordData           (WordData),
    .WordReady          (WordReady),
    .ShiftEn            (ShiftEn),
    .NumShift           (NumShift),
    .BitsOut            (BitsOut),
    .BarrelShifterReady (BarrelShifterReady),
`ifdef CAVLC_BITCNT_EN
    .BitsConsumed       (BitsConsumed),
`endif
    .Underflow          (Underflow)
  );

  always #5 Clk = ~Clk;

  // model: 0 idle, 1 fill, 2 run, 3 err
  int          m_st;
  bit          mq[$];
  bit          m_und;
  logic [31:0] m_cnt;
  bit          m_rdy;

  always @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      m_st = 0;
      mq.delete();
      m_und = 0;
      m_cnt = 0;
    end else if (Start) begin
      m_st = 1;
      mq.delete();
      m_und = 0;
      m_cnt = 0;
    end else if (Stop) begin
      m_st = 0;
    end else begin
      m_rdy = (m_st == 1 || m_st == 2) && mq.size() <= 32;
      if (m_st == 2 && ShiftEn && int'(NumShift) > mq.size()) begin
        m_und = 1;
        m_st = 3;
      end else begin
        if (m_st == 2 && ShiftEn) begin
          for (int i = 0; i < int'(NumShift); i++) void'(mq.pop_front());
          m_cnt += 32'(NumShift);
        end
        if (WordValid && m_rdy)
          for (int i = 31; i >= 0; i--) mq.push_back(WordData[i]);
        if (m_st == 1 && mq.size() >= RB) m_st = 2;
      end
    end
  end

  function automatic logic [31:0] m_bits();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < mq.size()) r[31-i] = mq[i];
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    chk("m_WordReady", 32'(WordReady),
        32'((m_st == 1 || m_st == 2) && mq.size() <= 32));
    chk("m_BSReady", 32'(BarrelShifterReady),
        32'(m_st == 2 && mq.size() >= RB));
    chk("m_Underflow", 32'(Underflow), 32'(m_und));
    chk("m_BitsOut", BitsOut, m_bits());
    chk("m_Count", 32'(dut.u_buf.count_q), 32'(mq.size()));
`ifdef CAVLC_BITCNT_EN
    chk("m_BitsConsumed", BitsConsumed, m_cnt);
`endif
  end

  task automatic step(bit st, bit sp, bit wv, logic [31:0] wd,
                      bit se, logic [4:0] ns);
    @(negedge Clk);
    #1;
    Start = st;
    Stop = sp;
    WordValid = wv;
    WordData = wd;
    ShiftEn = se;
    NumShift = ns;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] cnt();
    return 32'(dut.u_buf.count_q);
  endfunction

  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_BitsOut", BitsOut, 32'h0);
    chk("rst_WordReady", 32'(WordReady), 32'h0);
    chk("rst_BSReady", 32'(BarrelShifterReady), 32'h0);
    chk("rst_Underflow", 32'(Underflow), 32'h0);
    #1 nReset = 1'b1;

    step(1, 0, 0, 32'h0, 0, 0);
    chk("start_WordReady", 32'(WordReady), 32'h1);
    step(0, 0, 1, 32'hA5A5A5A5, 0, 0);
    chk("w1_Count", cnt(), 32);
    chk("w1_BSReady", 32'(BarrelShifterReady), 32'h1);
    step(0, 0, 1, 32'h12345678, 0, 0);
    chk("w2_Count", cnt(), 64);
    chk("w2_WordReady", 32'(WordReady), 32'h0);
    chk("w2_BitsOut", BitsOut, 32'hA5A5A5A5);
    chk("w2_BSReady", 32'(BarrelShifterReady), 32'h1);
    step(0, 0, 0, 32'h0, 1, 4);
    chk("s4_BitsOut", BitsOut, 32'h5A5A5A51);
    chk("s4_Count", cnt(), 60);
    step(0, 0, 0, 32'h0, 1, 31);
    chk("s31_Count", cnt(), 29);
    chk("s31_WordReady", 32'(WordReady), 32'h1);
    chk("s31_BSReady", 32'(BarrelShifterReady), 32'h0);
    chk("s31_BitsOut", BitsOut, 32'h91A2B3C0);
    step(0, 0, 0, 32'h0, 1, 8);
    chk("s8_Count", cnt(), 21);
    chk("s8_BitsOut", BitsOut, 32'hA2B3C000);
`ifdef CAVLC_BITCNT_EN
    chk("cnt43", BitsConsumed, 32'd43);
`endif

    step(1, 0, 0, 32'h0, 0, 0);
    chk("restart_Count", cnt(), 0);
`ifdef CAVLC_BITCNT_EN
    chk("cnt_clr", BitsConsumed, 32'd0);
`endif
    step(0, 0, 1, 32'hA5A5A5A5, 0, 0);
    step(0, 0, 1, 32'h12345678, 0, 0);
    step(0, 0, 0, 32'h0, 1, 31);
    step(0, 0, 0, 32'h0, 1, 1);
    chk("c32_BitsOut", BitsOut, 32'h12345678);
    chk("c32_WordReady", 32'(WordReady), 32'h1);
    chk("c32_BSReady", 32'(BarrelShifterReady), 32'h1);
    step(0, 0, 1, 32'hFFFFFFFF, 1, 8);
    chk("merge_Count", cnt(), 56);
    chk("merge_BitsOut", BitsOut, 32'h345678FF);
    step(0, 0, 0, 32'h0, 1, 31);
    step(0, 0, 0, 32'h0, 1, 20);
    chk("c5_Count", cnt(), 5);
    chk("c5_BitsOut", BitsOut, 32'hF8000000);
    step(0, 0, 1, 32'hDEADBEEF, 1, 6);
    chk("uf_Underflow", 32'(Underflow), 32'h1);
    chk("uf_Count", cnt(), 5);
    chk("uf_WordReady", 32'(WordReady), 32'h0);
    step(0, 0, 1, 32'hDEADBEEF, 1, 0);
    chk("err_hold_Count", cnt(), 5);
    chk("err_hold_Underflow", 32'(Underflow), 32'h1);
    step(1, 0, 1, 32'hDEADBEEF, 0, 0);
    chk("uf_clr_Underflow", 32'(Underflow), 32'h0);
    chk("uf_clr_Count", cnt(), 0);
    chk("uf_clr_WordReady", 32'(WordReady), 32'h1);
    step(1, 0, 1, 32'hCAFEF00D, 0, 0);
    chk("start_drop_Count", cnt(), 0);
    step(1, 1, 1, 32'hCAFEF00D, 0, 0);
    chk("startstop_WordReady", 32'(WordReady), 32'h1);
    step(0, 0, 1, 32'hCAFEF00D, 0, 0);
    chk("fill_Count", cnt(), 32);
    step(0, 1, 0, 32'h0, 0, 0);
    chk("stop_Count", cnt(), 32);
    chk("stop_WordReady", 32'(WordReady), 32'h0);
    chk("stop_BSReady", 32'(BarrelShifterReady), 32'h0);
    chk("stop_BitsOut", BitsOut, 32'hCAFEF00D);
    step(0, 0, 1, 32'h11111111, 1, 0);
    chk("idle_Count", cnt(), 32);

    step(1, 0, 0, 32'h0, 0, 0);
    step(0, 0, 1, 32'h0F0F0F0F, 0, 0);
    @(negedge Clk);
    #1 nReset = 1'b0;
    #2;
    chk("arst_BitsOut", BitsOut, 32'h0);
    chk("arst_Count", cnt(), 0);
    chk("arst_WordReady", 32'(WordReady), 32'h0);
    #4 nReset = 1'b1;
    step(1, 0, 0, 32'h0, 0, 0);
    step(0, 0, 1, 32'h80000001, 0, 0);
    step(0, 0, 0, 32'h0, 1, 31);
    chk("post_BitsOut", BitsOut, 32'h80000000);
    step(0, 0, 0, 32'h0, 0, 0);

    @(negedge Clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitstream_fetch_ctrl.md
BITSTREAM_FETCH_CTRL -- requirements
Module: bitstream_fetch_ctrl

Interface
REQ-001 Parameter: READY_BITS, 32, minimum valid buffered bits for BarrelShifterReady; legal 1..32.
REQ-002 Clk  input  1  clock; all state updates on rising edge.
REQ-003 nReset  input  1  reset, asynchronous, active-low.
REQ-004 Start  input  1  one-cycle pulse: flush buffer, begin fetching a new bitstream.
REQ-005 Stop  input  1  one-cycle pulse: halt fetching, return to IDLE.
REQ-006 WordValid  input  1  upstream bitstream word valid.
REQ-007 WordData  input  32  upstream word; bit 31 is the first bit in stream order.
REQ-008 WordReady  output  1  block accepts WordData this cycle.
REQ-009 ShiftEn  input  1  decode FSM consumes NumShift bits this cycle.
REQ-010 NumShift  input  5  bits to consume, 0..31.
REQ-011 BitsOut  output  32  next 32 stream bits, MSB-aligned (BitsOut[31] = next bit).
REQ-012 BarrelShifterReady  output  1  valid bit count >= READY_BITS and state RUN.
REQ-013 Underflow  output  1  sticky error: a shift requested more bits than valid.

Function
REQ-014 Internal state: 64-bit buffer Buf (valid bits at Buf[63:64-Count]), 7-bit Count 0..64, and FSM states IDLE, FILL, RUN, ERR.
REQ-015 BitsOut = Buf[63:32] from registers; bits below Count are don't-care, but the implementation shall drive them 0.
REQ-016 WordReady = (state FILL or RUN) and Count <= 32, using only the registered Count; no combinational path from ShiftEn.
REQ-017 Accept = WordValid and WordReady; S = NumShift if (ShiftEn and state RUN and NumShift <= Count), else 0.
REQ-018 Next cycle: Buf' = (Buf << S) OR ({WordData,32'b0} >> (Count - S)) when Accept, else Buf << S; Count' = Count - S + 32*Accept.
REQ-019 Simultaneous shift and accept in one cycle shall both take effect per REQ-018; Count never exceeds 64.
REQ-020 IDLE -> FILL on Start; otherwise stays in IDLE.
REQ-021 FILL -> RUN when Count' >= READY_BITS; shifts are ignored in FILL.
REQ-022 RUN: when ShiftEn and NumShift > Count, set Underflow, perform no shift and no accept that cycle, and go to ERR.
REQ-023 ERR holds the buffer; WordReady = 0; leaves only on Start or Stop.
REQ-024 Stop in any state -> IDLE next cycle, with Buf/Count retained; Start has priority over Stop.
REQ-025 Start in any state: next cycle Buf = 0, Count = 0, Underflow = 0, state FILL; the same-cycle word or shift is discarded.
REQ-026 BarrelShifterReady is combinational from registered state/Count; it drops the cycle after Count falls below READY_BITS.
REQ-027 ShiftEn with NumShift = 0 is a legal no-op in every state.

Reset
REQ-028 On nReset low: state IDLE, Buf = 0, Count = 0, Underflow = 0, and therefore WordReady = 0, BarrelShifterReady = 0, BitsOut = 0.
REQ-029 Reset assertion mid-transfer discards buffered bits; no output glitches beyond the asynchronous clear.

Configuration
REQ-030 Macro CAVLC_BITCNT_EN: when defined, add output BitsConsumed (32-bit) = total bits shifted since last Start/reset, wrapping modulo 2^32; when undefined the port and counter are absent and behaviour is otherwise identical.

Structure
REQ-031 Shared package cavlc_pkg holds the FSM state enum type (fetch_state_t), WORD_W = 32, and BUF_W = 64.
REQ-032 One sub-module, bit_buffer: Buf/Count registers and the shift/merge datapath of REQ-018; the FSM and handshake stay in the top level.

Verification
REQ-033 Reset, then Start, then words 0xA5A5A5A5 and 0x12345678 back-to-back -> Count 64, WordReady 0, BitsOut 0xA5A5A5A5, BarrelShifterReady 1.
REQ-034 From REQ-033, ShiftEn NumShift=4 -> next BitsOut 0x5A5A5A51, Count 60; then NumShift=31 -> Count 29, WordReady 1, BarrelShifterReady 0.
REQ-035 Count 32, same cycle ShiftEn NumShift=8 and accept 0xFFFFFFFF -> Count 56, with the new word starting at BitsOut[7:0] = 0xFF.
REQ-036 Count 5 in RUN (READY_BITS=1), ShiftEn NumShift=6 -> Underflow 1, state ERR, Count stays 5, WordReady 0; Start -> Underflow 0, Count 0, FILL.
REQ-037 Start asserted while WordValid and WordReady are high -> word discarded, Count 0 next cycle; Stop and Start in the same cycle -> FILL.
REQ-038 With CAVLC_BITCNT_EN, shifts of 4, 31 and 8 after Start -> BitsConsumed 43; a subsequent Start -> 0.
